// File: rtl/uart_rx_buffered_pkg.sv
// uart_rx_buffered_pkg: deframer states, frame width, GPIO port indices and baud divider helper.
package uart_rx_buffered_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int FRAME_BITS = 8;
    localparam int GPIO_RX_BYTE_PORT = 4;
    localparam int GPIO_RX_VALID_PORT = 5;
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return (clk_freq + baud * os / 2) / (baud * os);
    endfunction
endpackage

// File: rtl/uart_rx_buffered_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO with count-based full/empty.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop & ~empty;
    // a pop in the same cycle frees the slot, so a push on full still lands
    assign do_push = push & (~full | do_pop);
    assign dout = empty ? '0 : mem[rptr];
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= din;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: oversampling 8N1 receiver feeding a show-ahead FIFO, with sticky error flags.
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              uart_txd_in,
    input  logic                              rx_pop,
    input  logic                              err_clr,
    output logic [FRAME_BITS-1:0]             rx_byte,
    output logic                              rx_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count,
    output logic                              frame_err,
    output logic                              overrun,
    output logic                              busy
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    logic [1:0] sync;
    logic rxs, rxs_q, tick, mid_start, bit_end, push, frame_evt, full, empty, ovf_evt;
    logic [DW-1:0] div_cnt;
    logic [SW-1:0] smp_cnt;
    logic [2:0] bit_idx;
    logic [FRAME_BITS-1:0] shreg;
    rx_state_t state;
    assign rxs = sync[1];
    assign tick = div_cnt == DW'(DIV - 1);
    assign mid_start = smp_cnt == SW'(OVERSAMPLE / 2 - 1);
    assign bit_end = smp_cnt == SW'(OVERSAMPLE - 1);
    assign push = state == STOP && tick && bit_end && rxs;
    assign frame_evt = state == STOP && tick && bit_end && !rxs;
    assign ovf_evt = push & full & ~rx_pop;
    assign busy = state != IDLE;
    assign rx_valid = ~empty;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= 2'b11;
            rxs_q <= 1'b1;
            div_cnt <= '0;
            state <= IDLE;
            smp_cnt <= '0;
            bit_idx <= '0;
            shreg <= '0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sync <= {sync[0], uart_txd_in};
            rxs_q <= rxs;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            frame_err <= frame_evt | (frame_err & ~err_clr);
            overrun <= ovf_evt | (overrun & ~err_clr);
            case (state)
                IDLE: if (rxs_q && !rxs) begin
                    smp_cnt <= '0;
                    state <= START;
                end
                START: if (tick) begin
                    smp_cnt <= mid_start ? '0 : smp_cnt + 1'b1;
                    bit_idx <= '0;
                    if (mid_start) state <= rxs ? IDLE : DATA;
                end
                DATA: if (tick) begin
                    smp_cnt <= bit_end ? '0 : smp_cnt + 1'b1;
                    if (bit_end) begin
                        shreg <= {rxs, shreg[FRAME_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                end
                STOP: if (tick) begin
                    smp_cnt <= bit_end ? '0 : smp_cnt + 1'b1;
                    if (bit_end) state <= IDLE;
                end
            endcase
        end
    end
    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(FRAME_BITS)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .din(shreg),
        .pop(rx_pop),
        .dout(rx_byte),
        .count(rx_count),
        .full(full),
        .empty(empty)
    );
endmodule
